// File: rtl/sensor_hub_pkg.sv
// Shared constants, state types and bit-timing helper for the sensor hub serial blocks.
package sensor_hub_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam int         PREFIX_LEN = 7;
  localparam logic [8*PREFIX_LEN-1:0] PREFIX = "Temp = ";

  typedef enum logic [1:0] {P_MATCH, P_DIGITS, P_EXPECT_LF, P_SKIP} parser_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic int clksPerBit(input int clkFreq, input int baud);
    return clkFreq / baud;
  endfunction

  // Character idx of PREFIX, counted from the left; out-of-range indices give 0.
  function automatic logic [7:0] prefixChar(input logic [2:0] idx);
    logic [8*PREFIX_LEN-1:0] w_shifted;
    w_shifted = PREFIX << (8 * idx);
    return w_shifted[8*PREFIX_LEN-1 -: 8];
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling, one-cycle valid / frame error pulses.
module uart_rx
  import sensor_hub_pkg::*;
#(
  parameter int CLK_FREQ = 1_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = clksPerBit(CLK_FREQ, BAUD);
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     r_state, w_nextState;
  logic [CW-1:0] r_cnt, w_nextCnt;
  logic [2:0]    r_bitIdx, w_nextBitIdx;
  logic [7:0]    r_shift, w_nextShift;
  logic          r_sync1, r_sync2, r_syncPrev;
  logic          r_valid, w_nextValid;
  logic          r_frameErr, w_nextFrameErr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_syncPrev <= 1'b1;
      r_state    <= RX_IDLE;
      r_cnt      <= '0;
      r_bitIdx   <= '0;
      r_shift    <= '0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_sync1    <= rx;
      r_sync2    <= r_sync1;
      r_syncPrev <= r_sync2;
      r_state    <= w_nextState;
      r_cnt      <= w_nextCnt;
      r_bitIdx   <= w_nextBitIdx;
      r_shift    <= w_nextShift;
      r_valid    <= w_nextValid;
      r_frameErr <= w_nextFrameErr;
    end
  end

  // The counter restarts at every sample point, so each phase compares against its own length.
  always_comb begin
    w_nextState    = r_state;
    w_nextCnt      = r_cnt + CW'(1);
    w_nextBitIdx   = r_bitIdx;
    w_nextShift    = r_shift;
    w_nextValid    = 1'b0;
    w_nextFrameErr = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_nextCnt = '0;
        if (r_syncPrev && !r_sync2) w_nextState = RX_START;
      end
      RX_START: begin
        if (r_cnt == HALF_LAST) begin
          w_nextCnt    = '0;
          w_nextBitIdx = '0;
          w_nextState  = r_sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == FULL_LAST) begin
          w_nextCnt   = '0;
          w_nextShift = {r_sync2, r_shift[7:1]};
          if (r_bitIdx == 3'd7) w_nextState = RX_STOP;
          else                  w_nextBitIdx = r_bitIdx + 3'd1;
        end
      end
      RX_STOP: begin
        if (r_cnt == FULL_LAST) begin
          w_nextCnt   = '0;
          w_nextState = RX_IDLE;
          if (r_sync2) w_nextValid    = 1'b1;
          else         w_nextFrameErr = 1'b1;
        end
      end
      default: w_nextState = RX_IDLE;
    endcase
  end

  assign rx_data   = r_shift;
  assign rx_valid  = r_valid;
  assign frame_err = r_frameErr;

endmodule

// File: rtl/ascii_uart_receiver.sv
// Receives "Temp = <n>\r\n" lines over UART and reports the parsed temperature or line errors.
module ascii_uart_receiver
  import sensor_hub_pkg::*;
#(
  parameter int CLK_FREQ = 1_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] temp_value,
  output logic       temp_valid,
  output logic       parse_err,
  output logic       frame_err
);

  logic [7:0] w_rxData;
  logic       w_rxValid;
  logic       w_frameErr;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (uart_rx),
    .rx_data  (w_rxData),
    .rx_valid (w_rxValid),
    .frame_err(w_frameErr)
  );

  parser_state_t r_state, w_nextState;
  logic [2:0]    r_idx, w_nextIdx;
  logic [9:0]    r_acc, w_nextAcc;
  logic [1:0]    r_ndig, w_nextNdig;
  logic [7:0]    r_tempValue;
  logic          r_tempValid, r_parseErr;
  logic          w_setValid, w_setErr;
  logic          w_isDigit, w_isLf, w_isCr;

  assign w_isDigit = (w_rxData >= ASCII_0) && (w_rxData <= ASCII_9);
  assign w_isLf    = (w_rxData == ASCII_LF);
  assign w_isCr    = (w_rxData == ASCII_CR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= P_MATCH;
      r_idx       <= '0;
      r_acc       <= '0;
      r_ndig      <= '0;
      r_tempValue <= '0;
      r_tempValid <= 1'b0;
      r_parseErr  <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_idx       <= w_nextIdx;
      r_acc       <= w_nextAcc;
      r_ndig      <= w_nextNdig;
      r_tempValid <= w_setValid;
      r_parseErr  <= w_setErr;
      if (w_setValid) r_tempValue <= r_acc[7:0];
    end
  end

  // A framing error abandons a partly received line silently; between lines it is ignored.
  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    w_nextAcc   = r_acc;
    w_nextNdig  = r_ndig;
    w_setValid  = 1'b0;
    w_setErr    = 1'b0;
    if (w_frameErr) begin
      if (!(r_state == P_MATCH && r_idx == 3'd0)) begin
        w_nextState = P_SKIP;
        w_nextIdx   = '0;
      end
    end else if (w_rxValid) begin
      case (r_state)
        P_MATCH: begin
          if (w_rxData == prefixChar(r_idx)) begin
            if (r_idx == 3'(PREFIX_LEN - 1)) begin
              w_nextState = P_DIGITS;
              w_nextIdx   = '0;
              w_nextAcc   = '0;
              w_nextNdig  = '0;
            end else begin
              w_nextIdx = r_idx + 3'd1;
            end
          end else if (!(r_idx == 3'd0 && (w_isCr || w_isLf))) begin
            w_setErr    = 1'b1;
            w_nextIdx   = '0;
            w_nextState = w_isLf ? P_MATCH : P_SKIP;
          end
        end
        P_DIGITS: begin
          if (w_isDigit && r_ndig < 2'd3) begin
            w_nextAcc  = r_acc * 10'd10 + {6'd0, w_rxData[3:0]};
            w_nextNdig = r_ndig + 2'd1;
          end else if (w_isCr && r_ndig != 2'd0) begin
            w_nextState = P_EXPECT_LF;
          end else begin
            w_setErr    = 1'b1;
            w_nextState = w_isLf ? P_MATCH : P_SKIP;
          end
        end
        P_EXPECT_LF: begin
          if (w_isLf) begin
            w_nextState = P_MATCH;
            if (r_acc <= 10'd255) w_setValid = 1'b1;
            else                  w_setErr   = 1'b1;
          end else begin
            w_setErr    = 1'b1;
            w_nextState = P_SKIP;
          end
        end
        P_SKIP: begin
          if (w_isLf) w_nextState = P_MATCH;
        end
        default: w_nextState = P_MATCH;
      endcase
    end
  end

  assign temp_value = r_tempValue;
  assign temp_valid = r_tempValid;
  assign parse_err  = r_parseErr;
  assign frame_err  = w_frameErr;

endmodule

// File: tb/tb_ascii_uart_receiver.sv
// Drives ASCII lines into ascii_uart_receiver bit by bit and checks pulses and temperature values.
`timescale 1ns/1ps
module tb_ascii_uart_receiver;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 62_500;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int LAT_MIN  = CPB / 2 + 9 * CPB + 1;
  localparam int LAT_MAX  = CPB / 2 + 9 * CPB + 5;
  localparam int GLITCH   = CPB / 2 - 2;
  localparam int NVEC     = 10;

  typedef struct {
    logic [7:0] text [16];
    int         len;
    int         badStop;
    int         expValid;
    int         expParseErr;
    int         expFrameErr;
    int         expTemp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uartRx = 1'b1;
  logic [7:0] temp_value;
  logic       temp_valid;
  logic       parse_err;
  logic       frame_err;

  int cycleCount = 0;
  int validCount = 0;
  int parseErrCount = 0;
  int frameErrCount = 0;
  int overlapCount = 0;
  int lastValidCycle = 0;
  int byteStartCycle = 0;
  int checks = 0;
  int passes = 0;

  vec_t vecs [NVEC];

  ascii_uart_receiver #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uartRx),
    .temp_value(temp_value),
    .temp_valid(temp_valid),
    .parse_err (parse_err),
    .frame_err (frame_err)
  );

  always #500 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  always @(negedge clk) begin
    if (temp_valid) begin
      validCount     <= validCount + 1;
      lastValidCycle <= cycleCount;
    end
    if (parse_err) parseErrCount <= parseErrCount + 1;
    if (frame_err) frameErrCount <= frameErrCount + 1;
    if (int'(temp_valid) + int'(parse_err) + int'(frame_err) > 1) overlapCount <= overlapCount + 1;
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation exceeded 80000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t makeVec(input string s, input int badStop, input int expValid,
                                   input int expParseErr, input int expFrameErr, input int expTemp);
    vec_t v;
    for (int i = 0; i < 16; i++) v.text[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) v.text[4'(i)] = s[i];
    v.len         = s.len();
    v.badStop     = badStop;
    v.expValid    = expValid;
    v.expParseErr = expParseErr;
    v.expFrameErr = expFrameErr;
    v.expTemp     = expTemp;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual >= lo && actual <= hi) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic goodStop);
    logic [7:0] sh;
    sh = b;
    @(negedge clk);
    uartRx = 1'b0;
    byteStartCycle = cycleCount;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uartRx = sh[0];
      sh = sh >> 1;
      repeat (CPB) @(negedge clk);
    end
    uartRx = goodStop;
    repeat (CPB) @(negedge clk);
    if (!goodStop) begin
      uartRx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < v.len; i++) sendByte(v.text[4'(i)], i != v.badStop);
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic checkLine(input string tag, input vec_t v, input int v0, input int p0, input int f0);
    checkOutput({tag, " temp_valid pulses"}, validCount - v0, v.expValid);
    checkOutput({tag, " parse_err pulses"}, parseErrCount - p0, v.expParseErr);
    checkOutput({tag, " frame_err pulses"}, frameErrCount - f0, v.expFrameErr);
    checkOutput({tag, " temp_value"}, int'(temp_value), v.expTemp);
  endtask

  initial begin
    int v0, p0, f0;

    vecs[0] = makeVec("Temp = 25\r\n",     -1, 1, 0, 0, 25);
    vecs[1] = makeVec("Temp = 255\r\n",    -1, 1, 0, 0, 255);
    vecs[2] = makeVec("Temp = 256\r\n",    -1, 0, 1, 0, 255);
    vecs[3] = makeVec("Tamp = 25\r\n",     -1, 0, 1, 0, 255);
    vecs[4] = makeVec("Temp = 7\r\n",      -1, 1, 0, 0, 7);
    vecs[5] = makeVec("Temp = 1234\r\n",   -1, 0, 1, 0, 7);
    vecs[6] = makeVec("Temp = \r\n",       -1, 0, 1, 0, 7);
    vecs[7] = makeVec("\r\nTemp = 0\r\n",  -1, 1, 0, 0, 0);
    vecs[8] = makeVec("Temp = 99\r\n",      2, 0, 0, 1, 0);
    vecs[9] = makeVec("Temp = 42\r\n",     -1, 1, 0, 0, 42);

    $display("[TB] reset phase");
    rst = 1'b1;
    uartRx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset temp_value", int'(temp_value), 0);
    checkOutput("reset temp_valid", int'(temp_valid), 0);
    checkOutput("reset parse_err", int'(parse_err), 0);
    checkOutput("reset frame_err", int'(frame_err), 0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    $display("[TB] line table");
    for (int k = 0; k < NVEC; k++) begin
      v0 = validCount;
      p0 = parseErrCount;
      f0 = frameErrCount;
      applyStimulus(vecs[k]);
      checkLine($sformatf("vec%0d", k), vecs[k], v0, p0, f0);
      if (k == 0) checkRange("vec0 LF start to temp_valid cycles", lastValidCycle - byteStartCycle,
                             LAT_MIN, LAT_MAX);
    end

    $display("[TB] short low glitch");
    v0 = validCount;
    p0 = parseErrCount;
    f0 = frameErrCount;
    @(negedge clk);
    uartRx = 1'b0;
    repeat (GLITCH) @(negedge clk);
    uartRx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    checkOutput("glitch temp_valid pulses", validCount - v0, 0);
    checkOutput("glitch parse_err pulses", parseErrCount - p0, 0);
    checkOutput("glitch frame_err pulses", frameErrCount - f0, 0);

    $display("[TB] reset mid-line and mid-byte");
    sendByte(8'h54, 1'b1);
    sendByte(8'h65, 1'b1);
    @(negedge clk);
    uartRx = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("mid reset temp_value", int'(temp_value), 0);
    checkOutput("mid reset temp_valid", int'(temp_valid), 0);
    checkOutput("mid reset parse_err", int'(parse_err), 0);
    checkOutput("mid reset frame_err", int'(frame_err), 0);
    rst = 1'b0;
    uartRx = 1'b1;
    repeat (4 * CPB) @(negedge clk);

    v0 = validCount;
    p0 = parseErrCount;
    f0 = frameErrCount;
    applyStimulus(makeVec("Temp = 9\r\n", -1, 1, 0, 0, 9));
    checkLine("after reset", makeVec("Temp = 9\r\n", -1, 1, 0, 0, 9), v0, p0, f0);

    checkOutput("cycles with overlapping pulses", overlapCount, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
